// File: rtl/result_drain.sv
// result_drain: snapshots the systolic array results on a done rising edge and streams them row-major over valid/ready.
// Define RESULT_DRAIN_SAT_EN to saturate each word to OUT_WIDTH and track sat_flag; otherwise words are truncated.
module result_drain #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int WIDTH     = 4,
  parameter int HEIGHT    = 4,
  localparam int N        = HEIGHT * WIDTH,
  localparam int IW       = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic [N*ACC_WIDTH-1:0]     result_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [IW-1:0]              out_index,
  output logic                       out_last,
  output logic                       overrun,
  output logic                       sat_flag
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t                 r_state, w_next;
  logic                   r_done_d, r_overrun;
  logic [IW-1:0]          r_idx;
  logic [ACC_WIDTH-1:0]   r_shadow [N];
  logic                   w_rise, w_xfer, w_last_idx, w_capture;
  logic [ACC_WIDTH-1:0]   w_acc;
  logic [OUT_WIDTH-1:0]   w_word;
  assign w_rise     = done & ~r_done_d;
  assign w_capture  = (r_state == IDLE) & w_rise;
  assign w_xfer     = out_valid & out_ready;
  assign w_last_idx = r_idx == IW'(N - 1);
  assign w_acc      = r_shadow[r_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_rise ? STREAM : IDLE;
    else                 w_next = (w_xfer & w_last_idx) ? IDLE : STREAM;
  end
  always_comb begin
    busy      = r_state == STREAM;
    out_valid = busy;
    out_data  = busy ? w_word : '0;
    out_index = r_idx;
    out_last  = busy & w_last_idx;
    overrun   = r_overrun;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_done_d  <= 1'b0;
      r_overrun <= 1'b0;
      r_idx     <= '0;
      r_shadow  <= '{default: '0};
    end else begin
      r_done_d  <= done;
      r_overrun <= busy & w_rise;
      if (w_capture) begin
        for (int k = 0; k < N; k++) r_shadow[k] <= result_in[k*ACC_WIDTH +: ACC_WIDTH];
        r_idx <= '0;
      end else if (w_xfer) r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
    end
`ifdef RESULT_DRAIN_SAT_EN
  logic w_over, r_sat;
  assign w_over   = (w_acc >> OUT_WIDTH) != '0;
  assign w_word   = w_over ? '1 : OUT_WIDTH'(w_acc);
  // flag shows the word on display immediately and latches once it is transferred
  assign sat_flag = r_sat | (busy & w_over);
  always_ff @(posedge clk or posedge rst)
    if (rst)                  r_sat <= 1'b0;
    else if (w_capture)       r_sat <= 1'b0;
    else if (w_xfer & w_over) r_sat <= 1'b1;
`else
  assign w_word   = OUT_WIDTH'(w_acc);
  assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: random and directed stimulus checked each cycle against a queue-based model of the drain.
module tb_result_drain;
  localparam int AW = 16, OW = 8, N = 16;
  logic clk = 0, rst = 1, done = 0, out_ready = 0;
  logic [N*AW-1:0] result_in = '0;
  logic busy, out_valid, out_last, overrun, sat_flag;
  logic [OW-1:0] out_data;
  logic [3:0] out_index;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  result_drain #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .WIDTH(4), .HEIGHT(4)) dut (
    .clk(clk), .rst(rst), .done(done), .result_in(result_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .overrun(overrun), .sat_flag(sat_flag));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [OW-1:0] narrow(input logic [AW-1:0] a);
`ifdef RESULT_DRAIN_SAT_EN
    return (a > 255) ? 8'hFF : OW'(a);
`else
    return OW'(a % 256);
`endif
  endfunction

  logic [AW-1:0] q[$];
  logic m_prev = 0, m_ovr = 0, m_sat = 0, m_rise, m_busy, e_v, e_sat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_prev = 0; m_ovr = 0; m_sat = 0;
    end else begin
      m_rise = done && !m_prev;
      m_busy = q.size() > 0;
      m_prev = done;
      m_ovr  = m_rise && m_busy;
      if (m_busy && out_ready) begin
        if (q[0] > 255) m_sat = 1;
        void'(q.pop_front());
      end else if (m_rise && !m_busy) begin
        m_sat = 0;
        for (int k = 0; k < N; k++) q.push_back(result_in[k*AW +: AW]);
      end
    end
  end

  logic [OW-1:0] got[$];
  int lasts = 0, ovr_cnt = 0;
  always @(negedge clk) begin
    e_v = q.size() > 0;
`ifdef RESULT_DRAIN_SAT_EN
    e_sat = m_sat || (e_v && q[0] > 255);
`else
    e_sat = 0;
`endif
    chk("valid", out_valid, e_v);
    chk("busy", busy, e_v);
    chk("data", out_data, e_v ? narrow(q[0]) : 0);
    chk("index", out_index, e_v ? N - q.size() : 0);
    chk("last", out_last, q.size() == 1);
    chk("overrun", overrun, m_ovr);
    chk("sat_flag", sat_flag, e_sat);
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      if (out_last) lasts++;
    end
    if (overrun) ovr_cnt++;
  end

  logic [AW-1:0] v [N];
  task automatic step(); @(posedge clk); #2; endtask
  task automatic load(); for (int k = 0; k < N; k++) result_in[k*AW +: AW] = v[k]; endtask
  task automatic rand_vals(input int hi); for (int k = 0; k < N; k++) v[k] = AW'($urandom_range(0, hi)); endtask
  task automatic pulse_done(); done = 1; step(); done = 0; endtask
  task automatic drain(input int mode);
    int c;
    for (c = 0; c < 300 && (out_valid || q.size() > 0); c++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      if (mode == 2) done = ($urandom_range(0, 9) == 0);
      step();
    end
    done = 0;
    chk("drain_timeout", c < 300, 1);
  endtask
  task automatic check_frame(input string nm);
    chk({nm, "_count"}, got.size(), N);
    for (int k = 0; k < N && k < got.size(); k++) chk({nm, "_word"}, got[k], narrow(v[k]));
  endtask

  int l0, o0;
  initial begin
    #100000 $display("FAIL watchdog"); $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0); chk("rst_index", out_index, 0);
    chk("rst_busy", busy, 0); chk("rst_sat", sat_flag, 0);
    rst = 0; step();
    // basic drain: values 1..16
    for (int k = 0; k < N; k++) v[k] = AW'(k + 1);
    load(); got.delete(); l0 = lasts;
    pulse_done();
    chk("latency_valid", out_valid, 1); chk("latency_word0", out_data, 1);
    out_ready = 1;
    repeat (16) step();
    chk("basic_valid_after", out_valid, 0); chk("basic_busy_after", busy, 0);
    chk("basic_count", got.size(), 16); chk("basic_lasts", lasts - l0, 1);
    for (int k = 0; k < N && k < got.size(); k++) chk("basic_word", got[k], k + 1);
    out_ready = 0; step();
    // backpressure
    rand_vals(255); load(); got.delete();
    pulse_done(); drain(1); check_frame("bp");
    // held done: exactly one frame
    rand_vals(255); load(); got.delete(); l0 = lasts; o0 = ovr_cnt;
    done = 1; out_ready = 1; repeat (40) step(); done = 0; step();
    chk("held_frames", lasts - l0, 1); chk("held_overrun", ovr_cnt - o0, 0); check_frame("held");
    // overrun at transfer 5
    rand_vals(255); load(); got.delete(); o0 = ovr_cnt; out_ready = 1;
    pulse_done();
    for (int i = 0; i < 50 && got.size() < 5; i++) step();
    for (int k = 0; k < N; k++) result_in[k*AW +: AW] = 16'h0077;
    pulse_done(); drain(0);
    chk("ovr_pulses", ovr_cnt - o0, 1); check_frame("ovr");
    // overrun on the final transfer drops that frame
    rand_vals(255); load(); got.delete(); o0 = ovr_cnt; out_ready = 0;
    pulse_done(); out_ready = 1;
    for (int i = 0; i < 50 && got.size() < 15; i++) step();
    pulse_done(); step();
    chk("ovr_last_pulse", ovr_cnt - o0, 1); chk("ovr_last_idle", out_valid, 0); check_frame("ovr_last");
    // snapshot isolation
    rand_vals(255); load(); got.delete(); out_ready = 0;
    pulse_done();
    for (int k = 0; k < N; k++) result_in[k*AW +: AW] = 16'h00AA;
    drain(1); check_frame("snap");
    // narrowing with PE(0,0)=300
    rand_vals(255); v[0] = 300; load(); got.delete(); out_ready = 0;
    pulse_done();
`ifdef RESULT_DRAIN_SAT_EN
    chk("narrow_word0", out_data, 255); chk("narrow_sat", sat_flag, 1);
`else
    chk("narrow_word0", out_data, 44); chk("narrow_sat", sat_flag, 0);
`endif
    drain(0);
`ifdef RESULT_DRAIN_SAT_EN
    chk("sat_sticky", sat_flag, 1);
`else
    chk("sat_sticky", sat_flag, 0);
`endif
    rand_vals(255); load(); pulse_done();
    chk("sat_cleared", sat_flag, 0); drain(0); chk("sat_cleared_end", sat_flag, 0);
    // reset mid-stream
    rand_vals(255); load(); got.delete(); out_ready = 1;
    pulse_done();
    for (int i = 0; i < 50 && got.size() < 7; i++) step();
    rst = 1; #1;
    chk("mid_rst_valid", out_valid, 0); chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", out_index, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_last", out_last, 0);
    step(); step(); rst = 0; out_ready = 0; step();
    rand_vals(255); load(); got.delete();
    pulse_done();
    chk("restart_index", out_index, 0); chk("restart_word0", out_data, narrow(v[0]));
    drain(0); check_frame("restart");
    // random frames with random ready and stray done pulses
    for (int f = 0; f < 8; f++) begin
      rand_vals(f % 2 ? 65535 : 511); load();
      pulse_done(); drain(2); drain(0);
      repeat ($urandom_range(0, 3)) step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the 4x4 systolic array. It snapshots every PE accumulator in one cycle when the array signals `done`, then streams the results out in row-major order over a valid/ready handshake, one word per transfer, narrowed from accumulator width to output width. Because it captures into shadow registers, the array can start its next computation while the previous result matrix is still draining.

## Interface
- `ACC_WIDTH`, default 16: width of each PE `result` accumulator.
- `OUT_WIDTH`, default 8: width of each streamed word; must be ≤ `ACC_WIDTH`.
- `WIDTH`, default 4: array columns.
- `HEIGHT`, default 4: array rows.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `done`  in  1  array-complete level from TOP; only its rising edge matters.
- `result_in`  in  `HEIGHT*WIDTH*ACC_WIDTH`  flattened PE results; PE(r,c) is at `[(r*WIDTH+c)*ACC_WIDTH +: ACC_WIDTH]`; unsigned.
- `busy`  out  1  high while a captured frame is being drained.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  `OUT_WIDTH`  current result word.
- `out_index`  out  `$clog2(HEIGHT*WIDTH)`  linear index r*WIDTH+c of `out_data`.
- `out_last`  out  1  high with the word at index `HEIGHT*WIDTH-1`.
- `overrun`  out  1  one-cycle pulse: a `done` edge arrived while busy, and that frame was dropped.
- `sat_flag`  out  1  sticky per frame; see Configuration.

## Operation
- States: IDLE and STREAM.
- Edge detect: a registered `done_d` is kept; `done_rise = done & ~done_d`. Holding `done` high does not cause a recapture.
- IDLE, on `done_rise`:
  - latch all `HEIGHT*WIDTH` results into the shadow array;
  - clear the index to 0 and clear `sat_flag`;
  - go to STREAM.
- STREAM:
  - `out_valid=1` and `busy=1`.
  - `out_data` is the narrowed shadow[index].
  - A transfer occurs when `out_valid & out_ready`; the index then increments.
  - The transfer at index `HEIGHT*WIDTH-1` returns the block to IDLE and resets the index to 0.
- Stall: if `out_ready=0`, `out_data`, `out_index` and `out_last` hold stable. `out_valid` is never withdrawn before a transfer.
- `done_rise` in STREAM: the shadow array is not modified and `overrun` pulses for one cycle.
  - This includes the cycle of the final transfer: the frame is dropped and there is no back-to-back capture.
- Narrowing without the macro: `out_data = acc[OUT_WIDTH-1:0]` (truncation).
- `out_data` is combinational from the shadow array and index. It is not a registered output path; there are no extra pipeline stages.

## Timing
- Reset values: state IDLE, `busy=0`, `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`, `overrun=0`, `sat_flag=0`, `done_d=0`, shadow array all zeros.
- Reset asserted mid-stream aborts the frame immediately (asynchronous). After release, the first `done_rise` starts a fresh frame.
- Latency: `done` sampled high at edge N (with `done_d=0`) gives `out_valid=1` and word 0 after edge N.
- Throughput: with `out_ready` held high, `HEIGHT*WIDTH` consecutive transfers. `out_valid` falls after the edge of the last transfer.
- `result_in` is sampled only at the capture edge; later changes have no effect on the current frame.
- Minimum spacing between accepted frames: `HEIGHT*WIDTH+1` cycles (one IDLE cycle).

## Configuration
- `RESULT_DRAIN_SAT_EN` defined:
  - each word saturates: if acc > 2^OUT_WIDTH−1, `out_data` is all ones and `sat_flag` sets;
  - `sat_flag` stays set until the next capture or reset.
- Not defined:
  - plain truncation to the low `OUT_WIDTH` bits;
  - `sat_flag` is tied to 0 and no compare logic is synthesized.

## Test plan
- Reset values, then a basic drain. Stimulus: results 1..16 in row-major order, pulse `done`, `out_ready=1`. Required response: 16 transfers in consecutive cycles with `out_data` 1..16 and `out_index` 0..15; `out_last` only on index 15; `busy` low the next cycle.
- Backpressure. Stimulus: toggle `out_ready` 1,0,0,1 repeating. Required response: data/index stable during stalls, no word lost or duplicated, all 16 values in order.
- Held `done` and overrun. Stimulus: hold `done` high for 40 cycles. Required response: exactly one frame. Separately, a fresh `done` edge at transfer 5 gives `overrun` high for 1 cycle and the remaining words come from the original snapshot.
- Snapshot isolation. Stimulus: change `result_in` to all 0xAA one cycle after capture. Required response: the stream still outputs the original values.
- Narrowing with PE(0,0)=300, `OUT_WIDTH=8`. With `RESULT_DRAIN_SAT_EN`: word 0 = 255 and `sat_flag=1`. Without it: word 0 = 44 and `sat_flag=0`. The next frame with all values < 256 clears `sat_flag`.
- Reset mid-stream. Stimulus: assert `rst` at transfer 7. Required response: outputs go to 0 at once. Then a new `done` edge restarts at index 0 with the new snapshot.
